// File: rtl/adc_sar_seq_param.sv
// adc_sar_seq_param
//   SAR conversion sequencer with oversampling and majority-vote averaging.
//   Each conversion samples, then runs a binary search MSB->LSB driving trial
//   codes to the cap matrix. The low AVG_BITS decisions each take 2*avg+1
//   comparator votes and keep the majority. 2^osr conversions are summed and
//   the sum is presented left-justified in result_out.
//
// Ports
//   clk_dig_in       digital clock
//   rst              asynchronous active-high reset
//   start_in         start a run (honoured only in IDLE)
//   continuous_in    restart automatically after DONE (latched at start)
//   osr_cfg_in       log2 conversions per result (latched, clamped)
//   avg_cfg_in       votes per averaged bit = 2*avg+1 (latched)
//   comparator_in    1 = Vin >= trial code
//   sample_out       sampling switch enable
//   enable_loop_out  clock-loop enable (SAMPLE/CONVERT/ACCUM)
//   dac_code_out     trial code to the cap matrix
//   busy_out         state != IDLE
//   result_out       left-justified oversampled sum, updated only on DONE
//   result_valid_out one-cycle pulse in DONE
//   state_dbg        current FSM state
//
// Handshake: start_in is a level qualifier, accepted on the edge where the
// FSM is in IDLE; result_valid_out is a single-cycle strobe with no back
// pressure, result_out is stable from that cycle until the next DONE.
module adc_sar_seq_param #(
  parameter int RES          = 12,
  parameter int AVG_BITS     = 4,
  parameter int OSR_LOG2_MAX = 4,
  parameter int OUT_W        = 16,
  parameter int SAMPLE_CYC   = 1
) (
  input  logic             clk_dig_in,
  input  logic             rst,
  input  logic             start_in,
  input  logic             continuous_in,
  input  logic [2:0]       osr_cfg_in,
  input  logic [1:0]       avg_cfg_in,
  input  logic             comparator_in,
  output logic             sample_out,
  output logic             enable_loop_out,
  output logic [RES-1:0]   dac_code_out,
  output logic             busy_out,
  output logic [OUT_W-1:0] result_out,
  output logic             result_valid_out,
  output logic [2:0]       state_dbg
);

  localparam int SUM_W = RES + OSR_LOG2_MAX;
  localparam int CNT_W = OSR_LOG2_MAX + 1;
  localparam int IW    = $clog2(RES + 1);
  localparam int SCW   = $clog2(SAMPLE_CYC + 1);

  localparam logic [2:0]     OSR_MAX   = 3'(OSR_LOG2_MAX);
  localparam logic [IW-1:0]  AVG_I     = IW'(AVG_BITS);
  localparam logic [IW-1:0]  TOP_I     = IW'(RES - 1);
  localparam logic [SCW-1:0] SAMP_LAST = SCW'(SAMPLE_CYC - 1);
  localparam logic [7:0]     SHIFT_MAX = 8'(OUT_W - RES);
  localparam logic [RES-1:0] MSB_TRIAL = {1'b1, {(RES-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAMPLE  = 3'd1,
    S_CONVERT = 3'd2,
    S_ACCUM   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state;
  logic [2:0]       osr_q;
  logic [1:0]       avg_q;
  logic             cont_q;
  logic [SCW-1:0]   samp_cnt;
  logic [IW-1:0]    bit_idx;
  logic [RES-1:0]   code;
  logic [2:0]       vote_ones;
  logic [2:0]       vote_taken;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] conv_cnt;

  logic [2:0]       ones_next;
  logic [2:0]       taken_next;
  logic [2:0]       vote_n;
  logic             bit_done;
  logic             bit_val;
  logic [RES-1:0]   code_next;
  logic [RES-1:0]   trial_next;
  logic [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_next;
  logic             conv_last;
  logic [7:0]       shamt;
  logic [2:0]       osr_clamped;

  assign state_dbg = state;

  always_comb begin
    ones_next   = vote_ones + {2'b00, comparator_in};
    taken_next  = vote_taken + 3'd1;
    // Averaged bits take 2*avg+1 votes, which is just {avg,1}.
    vote_n      = (bit_idx < AVG_I) ? {avg_q, 1'b1} : 3'd1;
    bit_done    = (taken_next == vote_n);
    // Majority: strictly more than half of an odd vote count.
    bit_val     = (ones_next > (vote_n >> 1));
    code_next   = code | (bit_val ? (RES'(1) << bit_idx) : '0);
    trial_next  = (bit_idx == '0) ? '0 : (RES'(1) << (bit_idx - IW'(1)));
    sum_next    = sum + SUM_W'(code);
    cnt_next    = conv_cnt + CNT_W'(1);
    conv_last   = (cnt_next == (CNT_W'(1) << osr_q));
    shamt       = SHIFT_MAX - {5'd0, osr_q};
    osr_clamped = (osr_cfg_in > OSR_MAX) ? OSR_MAX : osr_cfg_in;
  end

  always_ff @(posedge clk_dig_in or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      osr_q            <= '0;
      avg_q            <= '0;
      cont_q           <= 1'b0;
      samp_cnt         <= '0;
      bit_idx          <= '0;
      code             <= '0;
      vote_ones        <= '0;
      vote_taken       <= '0;
      sum              <= '0;
      conv_cnt         <= '0;
      sample_out       <= 1'b0;
      enable_loop_out  <= 1'b0;
      dac_code_out     <= '0;
      busy_out         <= 1'b0;
      result_out       <= '0;
      result_valid_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_in) begin
            state           <= S_SAMPLE;
            osr_q           <= osr_clamped;
            avg_q           <= avg_cfg_in;
            cont_q          <= continuous_in;
            samp_cnt        <= '0;
            sample_out      <= 1'b1;
            enable_loop_out <= 1'b1;
            busy_out        <= 1'b1;
            dac_code_out    <= '0;
          end
        end
        S_SAMPLE: begin
          if (samp_cnt == SAMP_LAST) begin
            state        <= S_CONVERT;
            sample_out   <= 1'b0;
            bit_idx      <= TOP_I;
            code         <= '0;
            vote_ones    <= '0;
            vote_taken   <= '0;
            dac_code_out <= MSB_TRIAL;
          end else begin
            samp_cnt <= samp_cnt + SCW'(1);
          end
        end
        S_CONVERT: begin
          if (bit_done) begin
            code       <= code_next;
            vote_ones  <= '0;
            vote_taken <= '0;
            if (bit_idx == '0) begin
              state        <= S_ACCUM;
              dac_code_out <= code_next;
            end else begin
              bit_idx      <= bit_idx - IW'(1);
              dac_code_out <= code_next | trial_next;
            end
          end else begin
            vote_ones  <= ones_next;
            vote_taken <= taken_next;
          end
        end
        S_ACCUM: begin
          sum          <= sum_next;
          conv_cnt     <= cnt_next;
          dac_code_out <= '0;
          if (conv_last) begin
            state            <= S_DONE;
            result_out       <= OUT_W'(sum_next) << shamt;
            result_valid_out <= 1'b1;
            enable_loop_out  <= 1'b0;
          end else begin
            state      <= S_SAMPLE;
            samp_cnt   <= '0;
            sample_out <= 1'b1;
          end
        end
        S_DONE: begin
          sum              <= '0;
          conv_cnt         <= '0;
          result_valid_out <= 1'b0;
          if (cont_q) begin
            state           <= S_SAMPLE;
            samp_cnt        <= '0;
            sample_out      <= 1'b1;
            enable_loop_out <= 1'b1;
          end else begin
            state    <= S_IDLE;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state            <= S_IDLE;
          sample_out       <= 1'b0;
          enable_loop_out  <= 1'b0;
          busy_out         <= 1'b0;
          result_valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sar_seq_param.sv
// tb_adc_sar_seq_param
//   Bench for adc_sar_seq_param (RES=12, AVG_BITS=4, SAMPLE_CYC=1, OUT_W=16).
//   The comparator is modelled as (vin >= dac_code_out), optionally with the
//   first vote of every averaged bit inverted.
module tb_adc_sar_seq_param;

  logic        clk;
  logic        rst;
  logic        start;
  logic        cont;
  logic [2:0]  osr;
  logic [1:0]  avg;
  logic        comp;
  logic        sample_out;
  logic        enable_loop_out;
  logic [11:0] dac;
  logic        busy_out;
  logic [15:0] result_out;
  logic        result_valid_out;
  logic [2:0]  state_dbg;

  logic [11:0] vin;
  logic        inv_mode;
  logic [11:0] prev_dac;
  logic [11:0] lsb;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  adc_sar_seq_param dut (
    .clk_dig_in       (clk),
    .rst              (rst),
    .start_in         (start),
    .continuous_in    (cont),
    .osr_cfg_in       (osr),
    .avg_cfg_in       (avg),
    .comparator_in    (comp),
    .sample_out       (sample_out),
    .enable_loop_out  (enable_loop_out),
    .dac_code_out     (dac),
    .busy_out         (busy_out),
    .result_out       (result_out),
    .result_valid_out (result_valid_out),
    .state_dbg        (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) prev_dac <= dac;

  // Comparator model; a new trial code marks the first vote of a bit.
  always_comb begin
    lsb  = dac & (~dac + 12'd1);
    comp = (vin >= dac) ^ (inv_mode && (dac != prev_dac) && (dac != 12'd0) && (lsb < 12'h010));
  end

  // scoreboard: compare each result pulse against the oldest expectation
  always @(negedge clk) begin
    if (!rst && result_valid_out) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL unexpected_valid: pulse at cycle %0d result=%h, none expected", cyc, result_out);
      end else begin
        logic [15:0] e;
        int          c;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        tests_run += 2;
        if (result_out !== e) begin
          fails++;
          $display("FAIL result: got %h expected %h", result_out, e);
        end
        if (cyc !== c) begin
          fails++;
          $display("FAIL valid_timing: valid at cycle %0d expected %0d", cyc, c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  function automatic int conv_period(input logic [1:0] a);
    return 1 + 8 + 4 * (2 * int'(a) + 1) + 1;
  endfunction

  function automatic int osr_eff(input logic [2:0] o);
    return (o > 3'd4) ? 4 : int'(o);
  endfunction

  task automatic flush_sb();
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // Drives a start pulse (or level if hold) and pushes the expected result.
  task automatic start_run(input logic [11:0] v, input logic [2:0] o, input logic [1:0] a,
                           input logic c, input logic hold, input logic [15:0] exp_res,
                           output int s);
    @(negedge clk);
    vin   = v;
    osr   = o;
    avg   = a;
    cont  = c;
    start = 1'b1;
    @(negedge clk);
    s = cyc;
    if (!hold) start = 1'b0;
    exp_q.push_back(exp_res);
    exp_cyc_q.push_back(s + (1 << osr_eff(o)) * conv_period(a));
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      fails++;
      $display("FAIL %s_timeout: %0d results still pending after %0d cycles", name, exp_q.size(), budget);
      flush_sb();
    end
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({sample_out, enable_loop_out, dac, busy_out, result_out, result_valid_out, state_dbg} !== '0) begin
      fails++;
      $display("FAIL %s: outputs s=%b e=%b dac=%h busy=%b res=%h v=%b st=%0d, required all 0",
               name, sample_out, enable_loop_out, dac, busy_out, result_out, result_valid_out, state_dbg);
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_single();
    int s;
    start_run(12'h806, 3'd0, 2'd0, 1'b0, 1'b0, 16'h8060, s);
    tests_run++;
    if ({sample_out, enable_loop_out, busy_out, dac} !== {3'b111, 12'h000}) begin
      fails++;
      $display("FAIL sample_phase: s/e/b=%b%b%b dac=%h, required 111 dac=000", sample_out, enable_loop_out, busy_out, dac);
    end
    @(negedge clk);
    tests_run++;
    if ({sample_out, dac} !== {1'b0, 12'h800}) begin
      fails++;
      $display("FAIL first_trial: sample=%b dac=%h, required 0 800", sample_out, dac);
    end
    wait_empty("single", 40);
    while (cyc < s + 15) @(negedge clk);
    tests_run++;
    if ({busy_out, enable_loop_out, result_out} !== {2'b00, 16'h8060}) begin
      fails++;
      $display("FAIL after_done: busy=%b en=%b res=%h, required 0 0 8060", busy_out, enable_loop_out, result_out);
    end
  endtask

  task automatic test_avg_vote();
    int s;
    repeat (3) @(negedge clk);
    tests_run++;
    if (result_out !== 16'h8060) begin
      fails++;
      $display("FAIL result_hold: res=%h, required 8060", result_out);
    end
    inv_mode = 1'b1;
    start_run(12'h806, 3'd0, 2'd1, 1'b0, 1'b0, 16'h8060, s);
    wait_empty("avg_vote", 60);
    inv_mode = 1'b0;
  endtask

  task automatic test_osr4();
    int s;
    logic [11:0] seq [4];
    seq[0] = 12'h806; seq[1] = 12'h800; seq[2] = 12'h004; seq[3] = 12'h000;
    start_run(seq[0], 3'd2, 2'd0, 1'b0, 1'b0, 16'h4028, s);
    osr = 3'd0;   // must be ignored mid-run
    for (int k = 1; k < 4; k++) begin
      repeat (14) @(negedge clk);
      vin = seq[k];
    end
    wait_empty("osr4", 40);
    repeat (20) @(negedge clk);   // a second pulse would show up as unexpected
  endtask

  task automatic test_reset_mid();
    int s;
    start_run(12'h5A5, 3'd0, 2'd0, 1'b0, 1'b0, 16'h5A50, s);
    repeat (7) @(negedge clk);
    tests_run++;
    if ({busy_out, dac} !== {1'b1, (12'h5A5 & 12'hFC0) | 12'h020}) begin
      fails++;
      $display("FAIL convert_bit5: busy=%b dac=%h, required 1 %h", busy_out, dac, (12'h5A5 & 12'hFC0) | 12'h020);
    end
    rst = 1'b1;
    #1;
    check_all_zero("async_reset_mid");
    flush_sb();
    @(negedge clk);
    rst = 1'b0;
    start_run(12'h123, 3'd0, 2'd0, 1'b0, 1'b0, 16'h1230, s);
    wait_empty("after_reset", 40);
  endtask

  task automatic test_continuous();
    int s;
    start_run(12'h3C5, 3'd0, 2'd0, 1'b1, 1'b1, 16'h3C50, s);
    exp_q.push_back(16'h3C50);
    exp_cyc_q.push_back(s + 29);
    exp_q.push_back(16'h3C50);
    exp_cyc_q.push_back(s + 44);
    repeat (5) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;   // extra start while busy must not disturb the sequence
    wait_empty("continuous", 80);
    rst   = 1'b1;
    start = 1'b0;
    cont  = 1'b0;
    flush_sb();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_osr_clamp();
    int s;
    start_run(12'hFFF, 3'd7, 2'd0, 1'b0, 1'b0, 16'hFFF0, s);
    wait_empty("osr_clamp", 260);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    cont     = 1'b0;
    osr      = 3'd0;
    avg      = 2'd0;
    vin      = 12'd0;
    inv_mode = 1'b0;
    test_reset();
    test_single();
    test_avg_vote();
    test_osr4();
    test_reset_mid();
    test_continuous();
    test_osr_clamp();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
